// File: rtl/typewriter_output.sv
// typewriter_output
//   CPU-to-console half of the typewriter path. Takes 6-bit FIO-DEC codes
//   from the CPU, tracks the lower/upper shift state and translates each
//   printing code to 7-bit ASCII. The result is queued in a small FIFO for
//   the text console. Carriage return (077) expands to CR followed by LF.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   tyo_data      FIO-DEC code, sampled while tyo_strobe is high in IDLE
//   tyo_strobe    one-cycle request from the CPU
//   tyo_busy      a code is in progress
//   tyo_done      one-cycle pulse: the code was consumed
//   overrun       sticky: a strobe arrived while not idle
//   upper_case    current shift state (1 = upper)
//   char_out      FIFO head byte (0 when the FIFO is empty)
//   char_valid    FIFO non-empty
//   char_ready    console takes the head on char_valid && char_ready
//   fifo_count    occupied FIFO entries, 0..DEPTH
module typewriter_output #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       tyo_data,
   input  logic             tyo_strobe,
   output logic             tyo_busy,
   output logic             tyo_done,
   output logic             overrun,
   output logic             upper_case,
   output logic [7:0]       char_out,
   output logic             char_valid,
   input  logic             char_ready,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, DECODE, PUSH1, PUSH2, DONE} state_t;

   state_t             state, state_nx;
   logic [5:0]         code_q;
   logic [6:0]         mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               map_vld;
   logic [6:0]         map_byte;
   logic               push, pop, room;
   logic [6:0]         push_byte;
   logic               is_case;

   // Code translation. The shift state cannot change while a printing
   // code is being pushed, so decoding straight from code_q is stable.
   always_comb begin
      map_vld  = 1'b1;
      map_byte = 7'h00;
      if (code_q == 6'o00)
         map_byte = 7'h20;
      else if (code_q == 6'o36)
         map_byte = 7'h09;
      else if (code_q == 6'o75)
         map_byte = 7'h08;
      else if (code_q == 6'o77)
         map_byte = 7'h0D;
      else if (code_q == 6'o20)
         map_byte = 7'h30;
      else if (code_q >= 6'o01 && code_q <= 6'o11)
         map_byte = 7'h30 + 7'(code_q);
      else if (code_q >= 6'o61 && code_q <= 6'o71)
         map_byte = (upper_case ? 7'h41 : 7'h61) + 7'(code_q - 6'o61);
      else if (code_q >= 6'o41 && code_q <= 6'o51)
         map_byte = (upper_case ? 7'h4A : 7'h6A) + 7'(code_q - 6'o41);
      else if (code_q >= 6'o22 && code_q <= 6'o31)
         map_byte = (upper_case ? 7'h53 : 7'h73) + 7'(code_q - 6'o22);
      else begin
         case (code_q)
            6'o33:   map_byte = upper_case ? 7'h3D : 7'h2C;
            6'o21:   map_byte = upper_case ? 7'h3F : 7'h2F;
            6'o57:   map_byte = upper_case ? 7'h5B : 7'h28;
            6'o55:   map_byte = upper_case ? 7'h5D : 7'h29;
            6'o73:   map_byte = upper_case ? 7'h78 : 7'h2E;
            6'o54:   map_byte = upper_case ? 7'h2B : 7'h2D;
            6'o40:   map_byte = upper_case ? 7'h5F : 7'h60;
            default: map_vld  = 1'b0;
         endcase
      end
   end

   assign is_case    = (code_q == 6'o72) || (code_q == 6'o74);

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign char_valid = (count != '0);
   assign pop        = char_valid && char_ready;
   assign room       = (count != CNT_W'(DEPTH)) || pop;
   assign push       = ((state == PUSH1) || (state == PUSH2)) && room;
   assign push_byte  = (state == PUSH2) ? 7'h0A : map_byte;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (tyo_strobe) state_nx = DECODE;
         DECODE: begin
            if (is_case || !map_vld) state_nx = DONE;
            else                     state_nx = PUSH1;
         end
         PUSH1:   if (room) state_nx = (code_q == 6'o77) ? PUSH2 : DONE;
         PUSH2:   if (room) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         code_q     <= 6'o00;
         upper_case <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && tyo_strobe)
            code_q <= tyo_data;
         if (state != IDLE && tyo_strobe)
            overrun <= 1'b1;
         if (state == DECODE && code_q == 6'o72)
            upper_case <= 1'b0;
         if (state == DECODE && code_q == 6'o74)
            upper_case <= 1'b1;
      end
   end

   // FIFO pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_byte;
   end

   assign char_out   = char_valid ? {1'b0, mem[rd_ptr]} : 8'h00;
   assign fifo_count = count;
   assign tyo_busy   = (state == DECODE) || (state == PUSH1) || (state == PUSH2);
   assign tyo_done   = (state == DONE);

endmodule
